// File: rtl/power_fault_logger_pkg.sv
// Shared definitions for the power fault logger: register map, bit positions,
// sel channel encodings and bus widths.
package power_fault_logger_pkg;

    localparam int unsigned AVS_ADDR_W = 2;
    localparam int unsigned AVS_DATA_W = 32;
    localparam int unsigned SEL_W      = 3;

    localparam logic [AVS_ADDR_W-1:0] PFL_ADDR_STATUS = 2'd0;
    localparam logic [AVS_ADDR_W-1:0] PFL_ADDR_DATA   = 2'd1;
    localparam logic [AVS_ADDR_W-1:0] PFL_ADDR_CTRL   = 2'd2;
    localparam logic [AVS_ADDR_W-1:0] PFL_ADDR_TIME   = 2'd3;

    localparam int unsigned STAT_NOT_EMPTY_BIT = 0;
    localparam int unsigned STAT_ERROR_BIT     = 1;
    localparam int unsigned STAT_OVERFLOW_BIT  = 2;
    localparam int unsigned STAT_COUNT_LSB     = 4;
    localparam int unsigned STAT_COUNT_W       = 4;

    localparam int unsigned CTRL_ACK_BIT     = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 2;

    // Comparator channel encodings shared with the power monitor
    typedef enum logic [SEL_W-1:0] {
        SEL_CH0  = 3'd0,
        SEL_CH1  = 3'd1,
        SEL_CH2  = 3'd2,
        SEL_CH3  = 3'd3,
        SEL_CH4  = 3'd4,
        SEL_CH5  = 3'd5,
        SEL_CH6  = 3'd6,
        SEL_IDLE = 3'b111
    } sel_e;

endpackage

// File: rtl/power_fault_logger_if.sv
// Avalon-MM register bus between the Nios CPU (master) and the fault logger (slave).
interface power_fault_logger_if;
    import power_fault_logger_pkg::*;

    logic [AVS_ADDR_W-1:0] avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [AVS_DATA_W-1:0] avs_writedata;
    logic [AVS_DATA_W-1:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/power_fault_logger_fifo.sv
// pfl_fifo: synchronous first-word-fall-through FIFO; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module pfl_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/power_fault_logger.sv
// Timestamps power-monitor faults into a FIFO readable over Avalon-MM, drives ack/irq.
// Optional POWER_FAULT_AUTO_ACK_EN: every capture also triggers an ack pulse.
module power_fault_logger
    import power_fault_logger_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TS_W     = 16,
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned ACK_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 error,
    input  logic [SEL_W-1:0]     sel,
    power_fault_logger_if.slave  avs,
    output logic                 irq,
    output logic                 ack
);
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned REC_W  = TS_W + SEL_W;
    localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W = 4;

    logic [PRE_W-1:0]      prescaler;
    logic [TS_W-1:0]       ts;
    logic                  error_d;
    logic                  overflow;
    logic                  irq_en;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [AVS_DATA_W-1:0] readdata;
    logic [AVS_DATA_W-1:0] rd_mux;

    logic [REC_W-1:0]      fifo_dout;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic                  capture;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  ctrl_wr;
    logic                  ack_trig;
    logic                  irq_en_next;
    logic [CNT_W-1:0]      count_next;
    logic [HOLD_W-1:0]     hold_next;
    logic                  unused_wdata;

    assign capture = error && !error_d;
    assign pop     = avs.avs_read && (avs.avs_address == PFL_ADDR_DATA) && !fifo_empty;
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;
    assign ctrl_wr = avs.avs_write && (avs.avs_address == PFL_ADDR_CTRL);

`ifdef POWER_FAULT_AUTO_ACK_EN
    assign ack_trig = (ctrl_wr && avs.avs_writedata[CTRL_ACK_BIT]) || capture;
`else
    assign ack_trig = ctrl_wr && avs.avs_writedata[CTRL_ACK_BIT];
`endif

    assign unused_wdata = ^avs.avs_writedata[AVS_DATA_W-1:CTRL_IRQ_EN_BIT+1];

    // irq follows the post-update state so it drops the cycle after the last pop
    assign irq_en_next = ctrl_wr ? avs.avs_writedata[CTRL_IRQ_EN_BIT] : irq_en;
    assign count_next  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign hold_next   = ack_trig          ? HOLD_W'(ACK_HOLD) :
                         (hold_cnt != '0)  ? hold_cnt - HOLD_W'(1) : '0;

    pfl_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({sel, ts}),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Timestamp base: ts advances once per TICK_DIV clocks
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            ts        <= '0;
        end else if (prescaler == PRE_W'(TICK_DIV - 1)) begin
            prescaler <= '0;
            ts        <= ts + TS_W'(1);
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (avs.avs_address)
            PFL_ADDR_STATUS: begin
                rd_mux[STAT_NOT_EMPTY_BIT]                   = !fifo_empty;
                rd_mux[STAT_ERROR_BIT]                       = error;
                rd_mux[STAT_OVERFLOW_BIT]                    = overflow;
                rd_mux[STAT_COUNT_LSB +: STAT_COUNT_W]       = STAT_COUNT_W'(fifo_count);
            end
            PFL_ADDR_DATA: begin
                if (!fifo_empty) rd_mux[REC_W-1:0] = fifo_dout;
            end
            PFL_ADDR_CTRL:   rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
            PFL_ADDR_TIME:   rd_mux[TS_W-1:0]        = ts;
            default:         rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_d  <= 1'b0;
            overflow <= 1'b0;
            irq_en   <= 1'b0;
            hold_cnt <= '0;
            ack      <= 1'b0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            error_d <= error;
            if (drop)
                overflow <= 1'b1;
            else if (ctrl_wr && avs.avs_writedata[CTRL_CLR_OVF_BIT])
                overflow <= 1'b0;
            irq_en   <= irq_en_next;
            hold_cnt <= hold_next;
            ack      <= (hold_next != '0);
            irq      <= irq_en_next && (count_next != '0);
            if (avs.avs_read) readdata <= rd_mux;
        end
    end

    assign avs.avs_readdata = readdata;
endmodule
